// File: rtl/dma_port_scheduler.sv
// Arbitrates CPU (port A), accelerator (port B) and a queued DMA requester onto
// the dual-port memory map; DMA borrows whichever port is idle, with a starvation guard on B.
module dma_port_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    CPUEn,
    input  logic                    CPUWrEn,
    input  logic [ADDR_WIDTH-1:0]   CPUAddr,
    input  logic [DATA_WIDTH-1:0]   CPUData,
    input  logic                    AclEn,
    input  logic                    AclWrEn,
    input  logic [ADDR_WIDTH-1:0]   AclAddr,
    input  logic [DATA_WIDTH-1:0]   AclData,
    output logic                    AclGnt,
    input  logic                    DMAReq,
    input  logic                    DMAWrEn,
    input  logic [ADDR_WIDTH-1:0]   DMAAddr,
    input  logic [DATA_WIDTH-1:0]   DMAData,
    output logic                    DMAReady,
    output logic [ADDR_WIDTH-1:0]   AddrA,
    output logic [DATA_WIDTH-1:0]   DataA,
    output logic                    WrA,
    output logic [ADDR_WIDTH-1:0]   AddrB,
    output logic [DATA_WIDTH-1:0]   DataB,
    output logic                    WrB,
    input  logic [DATA_WIDTH-1:0]   OutA,
    input  logic [DATA_WIDTH-1:0]   OutB,
    output logic [DATA_WIDTH-1:0]   CPUOut,
    output logic [DATA_WIDTH-1:0]   AclOut,
    output logic [DATA_WIDTH-1:0]   DMAOut,
    output logic                    CPUValid,
    output logic                    AclValid,
    output logic                    DMAValid,
    output logic [$clog2(DEPTH):0]  QueueCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FullCount  = (PW+1)'(DEPTH);
    localparam logic [SW-1:0] StarveMax  = SW'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] qAddr [DEPTH];
    logic [DATA_WIDTH-1:0] qData [DEPTH];
    logic [DEPTH-1:0]      qWr;

    logic [PW-1:0] rdPtrReg, wrPtrReg;
    logic [PW:0]   countReg;
    logic [SW-1:0] starveReg;
    logic          cpuPendReg, aclPendReg, dmaPendReg, dmaOnBReg;

    logic                  empty, full, enq, deq, forceB, issueA, issueB;
    logic                  headWr;
    logic [ADDR_WIDTH-1:0] headAddr;
    logic [DATA_WIDTH-1:0] headData;

    assign empty    = (countReg == '0);
    assign full     = (countReg == FullCount);
    assign headWr   = qWr[rdPtrReg];
    assign headAddr = qAddr[rdPtrReg];
    assign headData = qData[rdPtrReg];

    assign DMAReady = rst_n && !full;
    assign enq      = DMAReq && DMAReady;

    // A starving head steals port B from the accelerator for a single cycle.
    assign forceB   = rst_n && !empty && AclEn && (starveReg == StarveMax);
    assign issueB   = rst_n && !empty && (forceB || !AclEn);
    assign issueA   = rst_n && !empty && !issueB && !CPUEn;
    assign deq      = issueA || issueB;
    assign AclGnt   = rst_n && AclEn && !forceB;

    always_comb begin
        AddrA = CPUAddr;
        DataA = CPUData;
        WrA   = 1'b0;
        if (CPUEn) begin
            WrA = CPUWrEn && rst_n;
        end else if (issueA) begin
            AddrA = headAddr;
            DataA = headData;
            WrA   = headWr;
        end
    end

    always_comb begin
        AddrB = AclAddr;
        DataB = AclData;
        WrB   = 1'b0;
        if (issueB) begin
            AddrB = headAddr;
            DataB = headData;
            WrB   = headWr;
        end else if (AclEn) begin
            WrB = AclWrEn && rst_n;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            qWr[wrPtrReg]   <= DMAWrEn;
            qAddr[wrPtrReg] <= DMAAddr;
            qData[wrPtrReg] <= DMAData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtrReg   <= '0;
            wrPtrReg   <= '0;
            countReg   <= '0;
            starveReg  <= '0;
            cpuPendReg <= 1'b0;
            aclPendReg <= 1'b0;
            dmaPendReg <= 1'b0;
            dmaOnBReg  <= 1'b0;
        end else begin
            if (enq) wrPtrReg <= wrPtrReg + PW'(1);
            if (deq) rdPtrReg <= rdPtrReg + PW'(1);
            case ({enq, deq})
                2'b10:   countReg <= countReg + (PW+1)'(1);
                2'b01:   countReg <= countReg - (PW+1)'(1);
                default: countReg <= countReg;
            endcase
            if (empty || deq)
                starveReg <= '0;
            else if (starveReg != StarveMax)
                starveReg <= starveReg + SW'(1);
            cpuPendReg <= CPUEn && !CPUWrEn;
            aclPendReg <= AclGnt && !AclWrEn;
            dmaPendReg <= deq && !headWr;
            if (deq) dmaOnBReg <= issueB;
        end
    end

    assign CPUValid   = cpuPendReg;
    assign AclValid   = aclPendReg;
    assign DMAValid   = dmaPendReg;
    assign CPUOut     = OutA;
    assign AclOut     = OutB;
    assign DMAOut     = dmaOnBReg ? OutB : OutA;
    assign QueueCount = countReg;
endmodule

// File: doc/dma_port_scheduler.md
# dma_port_scheduler

Arbiter and DMA request queue for the dual-port memory map. CPU owns port A and the accelerator owns port B. DMA requests are buffered in a small FIFO and issued on whichever port is idle. A starvation guard lends port B to DMA for one cycle if it waits too long. The block sits between the three requesters and the memory_map ports; memory_map keeps its 1-cycle registered read latency.

## Interface
- DATA_WIDTH, 32, data width of all data buses
- ADDR_WIDTH, 32, address width of all address buses
- DEPTH, 4, DMA queue entries; power of two, at least 2
- STARVE_LIMIT, 8, wait cycles of the DMA queue head before port B is forced to DMA; at least 1
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- CPUEn, CPUWrEn  in  1 each  CPU request and write qualifier
- CPUAddr / CPUData  in  ADDR_WIDTH / DATA_WIDTH  CPU address and write data
- AclEn, AclWrEn  in  1 each  accelerator request and write qualifier
- AclAddr / AclData  in  ADDR_WIDTH / DATA_WIDTH  accelerator address and write data
- AclGnt  out  1  accelerator request accepted this cycle; when low, Acl must hold its request
- DMAReq, DMAWrEn  in  1 each  DMA request and write qualifier
- DMAAddr / DMAData  in  ADDR_WIDTH / DATA_WIDTH  DMA address and write data
- DMAReady  out  1  queue can accept; a transfer occurs when DMAReq and DMAReady are both high
- AddrA, DataA, WrA / AddrB, DataB, WrB  out  ADDR_WIDTH, DATA_WIDTH, 1  memory port drive
- OutA / OutB  in  DATA_WIDTH  memory read data, valid 1 cycle after the address
- CPUOut / AclOut / DMAOut  out  DATA_WIDTH  read data to each requester
- CPUValid / AclValid / DMAValid  out  1 each  1-cycle read-data strobes
- QueueCount  out  $clog2(DEPTH)+1  occupied queue entries

## Operation
- **Queue.** A DEPTH-entry FIFO stores {WrEn, Addr, Data}.
  - DMAReady = !full && rst_n. It is based on the registered count, so a full queue does not accept even when it dequeues in the same cycle.
  - An accepted request is earliest eligible for issue on the next cycle. There is no bypass path.
- **Port A.**
  - If CPUEn: drive CPU signals.
  - Else, if the DMA head is issued on A: drive the head entry.
  - Else: WrA = 0 and Addr/Data hold the CPU values.
- **Port B**, in priority order:
  - If the force condition holds: drive the DMA head and set AclGnt = 0.
  - Else if AclEn: drive Acl signals and set AclGnt = 1.
  - Else, if the head is issued on B: drive the head entry.
  - Else: WrB = 0.
- **DMA issue** (queue not empty), first match wins:
  - force → B
  - !AclEn → B
  - !CPUEn → A
  - otherwise stall
- **Dequeue.** The head is dequeued in its issue cycle. At most one DMA issue occurs per cycle.
- **Starvation counter.**
  - Increments on each cycle the queue is non-empty and the head stalls.
  - Clears on any head issue or when the queue is empty.
  - Saturates at STARVE_LIMIT.
  - force = (counter == STARVE_LIMIT) && queue non-empty && AclEn.
- **Read responses.**
  - CPUValid is asserted the cycle after CPUEn && !CPUWrEn, with CPUOut = OutA.
  - AclValid is asserted the cycle after an Acl read with AclGnt = 1, with AclOut = OutB.
  - DMAValid is asserted the cycle after a DMA read issue. DMAOut = OutA or OutB, selected by the port recorded at issue.
  - Writes produce no strobe.
- **Reset** (rst_n low at a clock edge):
  - Queue is emptied, counter cleared, pending responses dropped.
  - All valids are 0 and QueueCount is 0.
  - While rst_n is low: WrA = WrB = 0, AclGnt = 0, DMAReady = 0.
  - Asserting reset mid-operation discards queued DMA requests without issue.

## Timing
- All arbitration is combinational from the current inputs and registered queue state. Port drive and AclGnt settle in the same cycle.
- DMA minimum latency: accept at cycle N, issue at N+1, DMAValid at N+2.
- CPU and Acl reads: request at cycle N, valid at N+1. Zero added latency.
- Forced B grant lasts exactly 1 cycle, because issue clears the counter. The next force can occur no sooner than STARVE_LIMIT cycles later.
- Simultaneous enqueue and dequeue leaves QueueCount unchanged.
- Read pointers and write pointers wrap modulo DEPTH.

## Test plan
- **Idle-port DMA read.** With CPUEn = AclEn = 0, DMA read of 0x10 (memory holds 0xA5) accepted at cycle 0 → B issues the read at cycle 1 (port B drives 0x10); DMAValid = 1 and DMAOut = 0xA5 at cycle 2; QueueCount goes 1 → 0.
- **Port fallback.** With AclEn held high and CPUEn = 0, DMA write 0x55 to 0x20 → WrA = 1 at the issue cycle; a later CPU read of 0x20 returns 0x55.
- **Full queue.** With both CPUEn and AclEn high and STARVE_LIMIT large, push 5 requests with DEPTH = 4 → DMAReady goes 0 after the 4th; the 5th is held until the first issue; ordering is preserved on drain.
- **Starvation.** With STARVE_LIMIT = 3 and CPUEn/AclEn both high constantly, one DMA read queued → AclGnt = 0 and DMA drives B on exactly the 4th waiting cycle; AclGnt returns to 1 on the next cycle; Acl is re-granted, no duplicate issue occurs and AclValid is not asserted for the dropped cycle.
- **Simultaneous reads.** CPU reads 0x0 while Acl reads 0x4 in the same cycle → CPUValid and AclValid are both asserted the next cycle with the correct data.
- **Reset mid-operation.** Fill 3 entries, then drop rst_n for 1 cycle → QueueCount = 0 and no DMAValid is asserted; WrA = WrB = 0 during reset; DMAReady = 1 on the cycle after release.
